// File: rtl/fifo2_rr_merge_pkg.sv
// Shared types and helpers for the round-robin message merger.
// Arbiter FSM states and grant-index sizing.
package fifo2_rr_merge_pkg;

   localparam int NSRC_MIN = 2;
   localparam int NSRC_MAX = 16;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo2_rr_merge_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr,
// wrapping at NSRC (NSRC need not be a power of two).
module fifo2_rr_merge_rr_pick
   import fifo2_rr_merge_pkg::*;
#(
   parameter int NSRC = 4,
   parameter int IDW  = 2
) (
   input  logic [NSRC-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  idx,
   output logic            valid
);

   logic [IDW:0]   sum;
   logic [IDW-1:0] pos;

   // Walk offsets from far to near so the nearest hit wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      sum   = '0;
      pos   = '0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDW + 1)'(k);
         if (sum >= (IDW + 1)'(NSRC))
            sum = sum - (IDW + 1)'(NSRC);
         pos = sum[IDW-1:0];
         if (req[pos]) begin
            idx   = pos;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo2_rr_merge.sv
// Merges NSRC message streams into one FIFO, round-robin per
// message; a grant is held until the beat flagged LAST moves.
module fifo2_rr_merge
   import fifo2_rr_merge_pkg::*;
#(
   parameter int NSRC  = 4,
   parameter int width = 32,
   parameter int IDW   = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  CLR,
   input  logic [NSRC-1:0]       SRC_EMPTY_N,
   input  logic [NSRC*width-1:0] SRC_D_OUT,
   input  logic [NSRC-1:0]       SRC_LAST,
   output logic [NSRC-1:0]       SRC_DEQ,
   input  logic                  DST_FULL_N,
   output logic                  DST_ENQ,
   output logic [width-1:0]      DST_D_IN,
   output logic                  DST_LAST,
   output logic [IDW-1:0]        GRANT_ID,
   output logic                  BUSY
);

   if (NSRC < NSRC_MIN || NSRC > NSRC_MAX ||
       IDW != clog2_min1(NSRC)) begin : g_bad_param
      $error("fifo2_rr_merge: bad NSRC/IDW");
   end

   state_t         state;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] pick_idx;
   logic           pick_vld;
   logic           xfer;

   fifo2_rr_merge_rr_pick #(
      .NSRC (NSRC),
      .IDW  (IDW)
   ) u_pick (
      .req   (SRC_EMPTY_N),
      .ptr   (ptr),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // CLR gates the handshake in the same cycle it is seen.
   assign xfer = (state == XFER) & SRC_EMPTY_N[grant]
               & DST_FULL_N & ~CLR;

   always_comb begin
      SRC_DEQ = '0;
      if (xfer)
         SRC_DEQ[grant] = 1'b1;
   end

   assign DST_ENQ  = xfer;
   assign DST_D_IN = SRC_D_OUT[int'(grant)*width +: width];
   assign DST_LAST = SRC_LAST[grant];
   assign GRANT_ID = grant;
   assign BUSY     = (state == XFER);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else if (CLR) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant <= pick_idx;
                  state <= XFER;
               end
            end
            XFER: begin
               if (xfer && SRC_LAST[grant]) begin
                  ptr   <= (grant == IDW'(NSRC - 1)) ? '0 : grant + 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_deq_onehot : assert property (
      @(posedge CLK) disable iff (!RST_N) $onehot0(SRC_DEQ))
      else $warning("fifo2_rr_merge: SRC_DEQ not one-hot");

   a_enq_full : assert property (
      @(posedge CLK) disable iff (!RST_N) !(DST_ENQ && !DST_FULL_N))
      else $warning("fifo2_rr_merge: ENQ into full destination");

endmodule
